// File: rtl/clock_pkg.sv
// clock_pkg: shared types and helpers for the clock phase sequencer and its
// per-domain phase counters.
package clock_pkg;

  localparam int CLK_NUM_CLKS = 3;
  localparam int CLK_MAX_DIV  = 16;
  localparam int CLK_DIV_W    = $clog2(CLK_MAX_DIV + 1);

  typedef enum logic [1:0] {
    HOLD        = 2'd0,
    RUN         = 2'd1,
    SWITCH_WAIT = 2'd2
  } clk_state_e;

  // Packed ratio vector, domain 0 in the LSBs.
  typedef logic [CLK_NUM_CLKS*CLK_DIV_W-1:0] clk_div_vec_t;

  // Ratios 0 and 1 both mean "edge every cycle"; anything above the largest
  // legal ratio is clamped to it.
  function automatic logic [CLK_DIV_W-1:0] sanitize_div(
    input logic [CLK_DIV_W-1:0] raw,
    input int unsigned          max_div
  );
    logic [CLK_DIV_W-1:0] res;
    if (32'(raw) <= 32'd1) begin
      res = CLK_DIV_W'(1'b1);
    end else if (32'(raw) > max_div) begin
      res = CLK_DIV_W'(max_div);
    end else begin
      res = raw;
    end
    return res;
  endfunction

endpackage

// File: rtl/clock_phase_counter.sv
// clock_phase_counter: mirrors the phase of one clock divider. The count runs
// 0 .. div-1 and wraps; is_zero marks the divided clock's rising edge and
// is_last marks the final fast cycle of its period.
module clock_phase_counter
  import clock_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 clear,
  input  logic [CLK_DIV_W-1:0] div,
  output logic                 is_zero,
  output logic                 is_last
);

  logic [CLK_DIV_W-1:0] cnt_r;
  logic [CLK_DIV_W-1:0] last_val_s;

  // div is always sanitized to at least 1, so div-1 never underflows.
  assign last_val_s = div - CLK_DIV_W'(1'b1);
  assign is_zero    = (cnt_r == '0);
  assign is_last    = (cnt_r == last_val_s);

  // Phase count: cleared on a ratio switch, otherwise free-running while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (run) begin
      if (is_last) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CLK_DIV_W'(1'b1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/clock_phase_sequencer.sv
// clock_phase_sequencer: drives the shared divider reset, tracks each divided
// clock's phase and applies runtime ratio changes at hyperperiod boundaries.
// The per-domain rising-edge strobe is named div_edge because "edge" is a
// reserved word.
// Optional statistics (hyper_cnt, switch_cnt) are built when the macro
// CLOCK_PHASE_SEQUENCER_STATS_EN is defined.
module clock_phase_sequencer
  import clock_pkg::*;
#(
  parameter int p_num_clks   = CLK_NUM_CLKS,
  parameter int p_max_div    = CLK_MAX_DIV,
  parameter int p_rst_cycles = 4,
  parameter logic [p_num_clks*CLK_DIV_W-1:0] p_div_init = {5'd9, 5'd3, 5'd2}
) (
  input  logic                              clk,
  input  logic                              clk_reset_n,
  input  logic                              cfg_val,
  output logic                              cfg_rdy,
  input  logic [p_num_clks*CLK_DIV_W-1:0]   cfg_div,
  output logic                              clk_div_reset,
  output logic [p_num_clks*CLK_DIV_W-1:0]   cur_div,
  output logic [p_num_clks-1:0]             div_edge,
  output logic                              aligned,
  output logic                              busy
`ifdef CLOCK_PHASE_SEQUENCER_STATS_EN
  ,
  output logic [15:0]                       hyper_cnt,
  output logic [7:0]                        switch_cnt
`endif
);

  localparam int HOLD_W = (p_rst_cycles > 1) ? $clog2(p_rst_cycles) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(p_rst_cycles - 1);

  clk_state_e                        state_r;
  logic [HOLD_W-1:0]                 hold_cnt_r;
  logic [p_num_clks*CLK_DIV_W-1:0]   pend_div_r;
  logic [p_num_clks*CLK_DIV_W-1:0]   init_san_s;
  logic [p_num_clks*CLK_DIV_W-1:0]   cfg_san_s;
  logic [p_num_clks-1:0]             zero_s;
  logic [p_num_clks-1:0]             last_s;
  logic                              running_s;
  logic                              all_last_s;
  logic                              switch_s;

  assign running_s  = (state_r != HOLD);
  assign all_last_s = &last_s;
  // Last cycle of the hyperperiod while a new ratio set is pending.
  assign switch_s   = (state_r == SWITCH_WAIT) && all_last_s;

  for (genvar g = 0; g < p_num_clks; g++) begin : g_dom
    assign init_san_s[g*CLK_DIV_W +: CLK_DIV_W] =
      sanitize_div(p_div_init[g*CLK_DIV_W +: CLK_DIV_W], unsigned'(p_max_div));
    assign cfg_san_s[g*CLK_DIV_W +: CLK_DIV_W] =
      sanitize_div(cfg_div[g*CLK_DIV_W +: CLK_DIV_W], unsigned'(p_max_div));

    clock_phase_counter u_cnt (
      .clk     (clk),
      .rst_n   (clk_reset_n),
      .run     (running_s),
      .clear   (switch_s),
      .div     (cur_div[g*CLK_DIV_W +: CLK_DIV_W]),
      .is_zero (zero_s[g]),
      .is_last (last_s[g])
    );
  end

  // Strobes decode straight from the counters; they are silent while the
  // dividers are held in reset.
  assign div_edge = zero_s & {p_num_clks{running_s}};
  assign aligned  = &div_edge;

  // Sequencer FSM: divider reset hold, free run, and pending ratio switch.
  always_ff @(posedge clk or negedge clk_reset_n) begin
    if (!clk_reset_n) begin
      state_r       <= HOLD;
      hold_cnt_r    <= '0;
      pend_div_r    <= init_san_s;
      cur_div       <= init_san_s;
      clk_div_reset <= 1'b1;
      cfg_rdy       <= 1'b0;
      busy          <= 1'b1;
    end else begin
      case (state_r)
        HOLD: begin
          if (hold_cnt_r == HOLD_LAST) begin
            state_r       <= RUN;
            hold_cnt_r    <= '0;
            clk_div_reset <= 1'b0;
            cfg_rdy       <= 1'b1;
            busy          <= 1'b0;
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1'b1);
          end
        end
        RUN: begin
          if (cfg_val && cfg_rdy) begin
            pend_div_r <= cfg_san_s;
            state_r    <= SWITCH_WAIT;
            cfg_rdy    <= 1'b0;
            busy       <= 1'b1;
          end
        end
        SWITCH_WAIT: begin
          // Counters clear in the phase counters on the same edge.
          if (all_last_s) begin
            cur_div       <= pend_div_r;
            state_r       <= HOLD;
            hold_cnt_r    <= '0;
            clk_div_reset <= 1'b1;
          end
        end
        default: begin
          state_r       <= HOLD;
          hold_cnt_r    <= '0;
          clk_div_reset <= 1'b1;
          cfg_rdy       <= 1'b0;
          busy          <= 1'b1;
        end
      endcase
    end
  end

`ifdef CLOCK_PHASE_SEQUENCER_STATS_EN
  // Saturating counts of aligned cycles and completed ratio switches.
  always_ff @(posedge clk or negedge clk_reset_n) begin
    if (!clk_reset_n) begin
      hyper_cnt  <= 16'd0;
      switch_cnt <= 8'd0;
    end else begin
      if (aligned && (hyper_cnt != 16'hFFFF)) begin
        hyper_cnt <= hyper_cnt + 16'd1;
      end else begin
        hyper_cnt <= hyper_cnt;
      end
      if (switch_s && (switch_cnt != 8'hFF)) begin
        switch_cnt <= switch_cnt + 8'd1;
      end else begin
        switch_cnt <= switch_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_clock_phase_sequencer.sv
// tb_clock_phase_sequencer: table-driven bench for clock_phase_sequencer.
// Each table row holds the inputs for one fast cycle and the outputs expected
// during that cycle; rows are compared on the falling edge.
module tb_clock_phase_sequencer;
  import clock_pkg::*;

  localparam clk_div_vec_t DIV_INIT  = {5'd9, 5'd3, 5'd2};
  localparam clk_div_vec_t DIV_A     = {5'd1, 5'd2, 5'd4};
  localparam clk_div_vec_t DIV_B     = {5'd16, 5'd31, 5'd0};
  localparam clk_div_vec_t DIV_B_SAN = {5'd16, 5'd16, 5'd1};
  localparam clk_div_vec_t DIV_C     = {5'd7, 5'd7, 5'd7};
  localparam clk_div_vec_t DIV_ZERO  = {5'd0, 5'd0, 5'd0};

  logic         clk;
  logic         rst_n;
  logic         cfg_val;
  logic         cfg_rdy;
  clk_div_vec_t cfg_div;
  logic         clk_div_reset;
  clk_div_vec_t cur_div;
  logic [2:0]   div_edge;
  logic         aligned;
  logic         busy;
`ifdef CLOCK_PHASE_SEQUENCER_STATS_EN
  logic [15:0]  hyper_cnt;
  logic [7:0]   switch_cnt;
`endif

  typedef struct {
    logic         val;
    clk_div_vec_t div;
    logic [2:0]   e_edge;
    logic         e_al;
    logic         e_rst;
    logic         e_rdy;
    logic         e_busy;
    clk_div_vec_t e_cur;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_hyper = 0;

  clock_phase_sequencer dut (
    .clk           (clk),
    .clk_reset_n   (rst_n),
    .cfg_val       (cfg_val),
    .cfg_rdy       (cfg_rdy),
    .cfg_div       (cfg_div),
    .clk_div_reset (clk_div_reset),
    .cur_div       (cur_div),
    .div_edge      (div_edge),
    .aligned       (aligned),
    .busy          (busy)
`ifdef CLOCK_PHASE_SEQUENCER_STATS_EN
    ,
    .hyper_cnt     (hyper_cnt),
    .switch_cnt    (switch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // One cycle with the dividers held in reset.
  task automatic add_hold(input clk_div_vec_t cur);
    vec_t v;
    v.val = 1'b0;  v.div = DIV_ZERO;
    v.e_edge = 3'b000; v.e_al = 1'b0; v.e_rst = 1'b1;
    v.e_rdy = 1'b0; v.e_busy = 1'b1; v.e_cur = cur;
    tbl.push_back(v);
  endtask

  // Cycle k after leaving HOLD with ratios d0,d1,d2: domain i rises when k is
  // a multiple of its ratio.
  task automatic add_run(input int k, input int d0, input int d1, input int d2,
                         input clk_div_vec_t cur, input logic rdy,
                         input logic val, input clk_div_vec_t div);
    vec_t v;
    logic [2:0] e;
    e[0] = ((k % d0) == 0);
    e[1] = ((k % d1) == 0);
    e[2] = ((k % d2) == 0);
    v.val = val;  v.div = div;
    v.e_edge = e; v.e_al = &e; v.e_rst = 1'b0;
    v.e_rdy = rdy; v.e_busy = !rdy; v.e_cur = cur;
    tbl.push_back(v);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      check({tag, ".edge"},    i, 32'(div_edge),      32'(tbl[i].e_edge));
      check({tag, ".aligned"}, i, 32'(aligned),       32'(tbl[i].e_al));
      check({tag, ".divrst"},  i, 32'(clk_div_reset), 32'(tbl[i].e_rst));
      check({tag, ".rdy"},     i, 32'(cfg_rdy),       32'(tbl[i].e_rdy));
      check({tag, ".busy"},    i, 32'(busy),          32'(tbl[i].e_busy));
      check({tag, ".cur_div"}, i, 32'(cur_div),       32'(tbl[i].e_cur));
      if (tbl[i].e_al) exp_hyper++;
      cfg_val = tbl[i].val;
      cfg_div = tbl[i].div;
      @(negedge clk);
    end
    cfg_val = 1'b0;
    cfg_div = DIV_ZERO;
    tbl.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".edge"},    0, 32'(div_edge),      32'd0);
    check({tag, ".aligned"}, 0, 32'(aligned),       32'd0);
    check({tag, ".divrst"},  0, 32'(clk_div_reset), 32'd1);
    check({tag, ".rdy"},     0, 32'(cfg_rdy),       32'd0);
    check({tag, ".busy"},    0, 32'(busy),          32'd1);
    check({tag, ".cur_div"}, 0, 32'(cur_div),       32'(DIV_INIT));
`ifdef CLOCK_PHASE_SEQUENCER_STATS_EN
    check({tag, ".hyper"},   0, 32'(hyper_cnt),     32'd0);
    check({tag, ".switch"},  0, 32'(switch_cnt),    32'd0);
`endif
  endtask

  initial begin
    rst_n   = 1'b0;
    cfg_val = 1'b0;
    cfg_div = DIV_ZERO;
    repeat (2) @(negedge clk);
    check_reset_state("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Reset release, free run, switch to (4,2,1), clamped switch, then a
    // switch left pending when reset hits.
    for (int i = 0; i < 3; i++) add_hold(DIV_INIT);
    for (int t = 0; t <= 36; t++) add_run(t, 2, 3, 9, DIV_INIT, 1'b1, 1'b0, DIV_ZERO);
    for (int t = 37; t <= 53; t++)
      add_run(t, 2, 3, 9, DIV_INIT, (t <= 41), (t == 41), (t == 41) ? DIV_A : DIV_ZERO);
    for (int i = 0; i < 4; i++) add_hold(DIV_A);
    for (int r = 0; r <= 3; r++)
      add_run(r, 4, 2, 1, DIV_A, (r <= 1), (r == 1) || (r == 2),
              (r == 1) ? DIV_B : ((r == 2) ? DIV_C : DIV_ZERO));
    for (int i = 0; i < 4; i++) add_hold(DIV_B_SAN);
    for (int q = 0; q <= 20; q++)
      add_run(q, 1, 16, 16, DIV_B_SAN, (q <= 17), (q == 17), (q == 17) ? DIV_A : DIV_ZERO);
    run_table("main");

`ifdef CLOCK_PHASE_SEQUENCER_STATS_EN
    check("stats.hyper",  0, 32'(hyper_cnt),  32'(exp_hyper));
    check("stats.switch", 0, 32'(switch_cnt), 32'd2);
`endif

    // Reset in the middle of SWITCH_WAIT must act at once, before any edge.
    #2 rst_n = 1'b0;
    #1 check_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) add_hold(DIV_INIT);
    for (int t = 0; t <= 9; t++) add_run(t, 2, 3, 9, DIV_INIT, 1'b1, 1'b0, DIV_ZERO);
    run_table("rerun");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
